// File: rtl/step_dir_decoder.sv
// STEP/DIR receiver: synchronizes and glitch-filters an external step stream,
// tracks signed microstep position, measures step period and flags stalls.
module step_dir_decoder #(
    parameter int POS_W    = 32,
    parameter int PER_W    = 26,
    parameter int MIN_HIGH = 4,
    parameter int TIMEOUT  = 50000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step_in,
    input  logic                    dir_in,
    input  logic                    clr_pos,
    output logic signed [POS_W-1:0] position,
    output logic                    step_pulse,
    output logic [PER_W-1:0]        period,
    output logic                    period_valid,
    output logic                    stalled
);

    localparam int HW = $clog2(MIN_HIGH + 1);

    localparam logic [HW-1:0]    HI_MAX = HW'(MIN_HIGH);
    localparam logic [HW-1:0]    HI_ACC = HW'(MIN_HIGH - 1);
    localparam logic [PER_W-1:0] TMO    = PER_W'(TIMEOUT);
    localparam logic [PER_W-1:0] PER_1  = PER_W'(1);
    localparam logic [POS_W-1:0] POS_1  = POS_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FIRST = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]       step_sync_q;
    logic [1:0]       dir_sync_q;
    logic [HW-1:0]    hi_cnt_q, hi_cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [1:0]       state_q, state_d;
    logic             stalled_q, stalled_d;
    logic             step_pulse_q;
    logic             pv_q, pv_d;

    logic             step_s;
    logic             dir_s;
    logic             accept;
    logic [POS_W-1:0] pos_base;

    assign step_s = step_sync_q[1];
    assign dir_s  = dir_sync_q[1];

    // hi_cnt parks at MIN_HIGH so a long pulse is accepted only once
    assign accept = step_s && (hi_cnt_q == HI_ACC);

    always_comb begin
        hi_cnt_d = '0;
        if (step_s) begin
            hi_cnt_d = (hi_cnt_q == HI_MAX) ? hi_cnt_q : hi_cnt_q + 1'b1;
        end
    end

    // A clear coinciding with a step lands on +/-1
    always_comb begin
        pos_base = clr_pos ? '0 : pos_q;
        pos_d    = pos_base;
        if (accept) begin
            pos_d = dir_s ? pos_base + POS_1 : pos_base - POS_1;
        end
    end

    always_comb begin
        per_cnt_d = per_cnt_q;
        if (accept) begin
            per_cnt_d = PER_1;
        end else if (per_cnt_q != TMO) begin
            per_cnt_d = per_cnt_q + PER_1;
        end
    end

    always_comb begin
        state_d   = state_q;
        stalled_d = stalled_q;
        period_d  = period_q;
        pv_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_FIRST;
                    stalled_d = 1'b0;
                end
            end
            S_FIRST, S_RUN: begin
                if (accept) begin
                    period_d = per_cnt_q;
                    pv_d     = 1'b1;
                    state_d  = S_RUN;
                end else if (per_cnt_q == TMO) begin
                    stalled_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                stalled_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_sync_q  <= '0;
            dir_sync_q   <= '0;
            hi_cnt_q     <= '0;
            pos_q        <= '0;
            per_cnt_q    <= '0;
            period_q     <= '0;
            state_q      <= S_IDLE;
            stalled_q    <= 1'b1;
            step_pulse_q <= 1'b0;
            pv_q         <= 1'b0;
        end else begin
            step_sync_q  <= {step_sync_q[0], step_in};
            dir_sync_q   <= {dir_sync_q[0], dir_in};
            hi_cnt_q     <= hi_cnt_d;
            pos_q        <= pos_d;
            per_cnt_q    <= per_cnt_d;
            period_q     <= period_d;
            state_q      <= state_d;
            stalled_q    <= stalled_d;
            step_pulse_q <= accept;
            pv_q         <= pv_d;
        end
    end

    assign position     = pos_q;
    assign step_pulse   = step_pulse_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign stalled      = stalled_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Randomized bench for step_dir_decoder against an event-level model
// of expected step edges, position, period and stall status.
module tb_step_dir_decoder;

    localparam int POS_W    = 8;
    localparam int PER_W    = 12;
    localparam int MIN_HIGH = 4;
    localparam int TIMEOUT  = 1000;
    localparam int SYNC     = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    step_in = 1'b0;
    logic                    dir_in = 1'b0;
    logic                    clr_pos = 1'b0;
    logic signed [POS_W-1:0] position;
    logic                    step_pulse;
    logic [PER_W-1:0]        period;
    logic                    period_valid;
    logic                    stalled;

    step_dir_decoder #(
        .POS_W(POS_W), .PER_W(PER_W),
        .MIN_HIGH(MIN_HIGH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .step_in(step_in), .dir_in(dir_in),
        .clr_pos(clr_pos), .position(position), .step_pulse(step_pulse),
        .period(period), .period_valid(period_valid), .stalled(stalled)
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_n;
        bit dir;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    bit  clr_smp = 1'b0;
    bit  mon_en = 1'b0;
    int  n_sp = 0;
    int  n_pv = 0;

    logic signed [POS_W-1:0] m_pos = '0;
    bit m_stall = 1'b1;
    int m_last = 0;
    int m_per = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        clr_smp <= clr_pos;
    end

    // Expected behaviour derived from the queue of scheduled step edges
    always @(negedge clk) begin
        if (mon_en) begin
            bit hit;
            bit e_pv;
            ev_t ev;
            hit  = exp_q.size() > 0 && exp_q[0].edge_n == cyc;
            e_pv = 1'b0;
            if (clr_smp) m_pos = '0;
            if (hit) begin
                ev = exp_q.pop_front();
                m_pos = ev.dir ? m_pos + 1 : m_pos - 1;
                if (m_stall) begin
                    m_stall = 1'b0;
                end else begin
                    e_pv  = 1'b1;
                    m_per = cyc - m_last;
                end
                m_last = cyc;
            end else if (!m_stall && cyc - m_last == TIMEOUT) begin
                m_stall = 1'b1;
            end
            if (step_pulse) n_sp++;
            if (period_valid) n_pv++;
            chk("step_pulse", int'(step_pulse), int'(hit));
            chk("period_valid", int'(period_valid), int'(e_pv));
            chk("position", int'(position), int'(m_pos));
            chk("period", int'(period), m_per);
            chk("stalled", int'(stalled), int'(m_stall));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        m_pos   = '0;
        m_stall = 1'b1;
        m_last  = 0;
        m_per   = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pos"}, int'(position), 0);
        chk({tag, "_sp"}, int'(step_pulse), 0);
        chk({tag, "_pv"}, int'(period_valid), 0);
        chk({tag, "_per"}, int'(period), 0);
        chk({tag, "_stall"}, int'(stalled), 1);
    endtask

    task automatic do_reset();
        mon_en  = 1'b0;
        rst     = 1'b0;
        step_in = 1'b0;
        clr_pos = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        chk_reset_outputs("rst");
        rst = 1'b1;
        reset_model();
        mon_en = 1'b1;
    endtask

    // High for len cycles, low for gap cycles; optional clear on the accept
    // edge (len >= 6) and optional random clears during the low phase
    task automatic pulse(input int len, input bit d, input int gap,
                         input bit c = 1'b0, input bit rc = 1'b0);
        int ed;
        ed      = cyc + SYNC + MIN_HIGH;
        step_in = 1'b1;
        dir_in  = d;
        if (len >= MIN_HIGH) exp_q.push_back('{ed, d});
        for (int i = 0; i < len; i++) begin
            clr_pos = c && (cyc == ed - 1);
            tick();
        end
        clr_pos = 1'b0;
        step_in = 1'b0;
        for (int i = 0; i < gap; i++) begin
            clr_pos = rc && ($urandom_range(0, 7) == 0);
            tick();
        end
        clr_pos = 1'b0;
    endtask

    initial begin
        int sp0;
        int pv0;
        do_reset();

        // idle after reset
        repeat (100) tick();
        chk("idle_steps", n_sp, 0);

        // forward run, 200-cycle square wave
        sp0 = n_sp;
        pv0 = n_pv;
        for (int i = 0; i < 10; i++) pulse(100, 1'b1, 100);
        chk("fwd_steps", n_sp - sp0, 10);
        chk("fwd_pv", n_pv - pv0, 9);
        chk("fwd_pos", int'(position), 10);
        chk("fwd_per", int'(period), 200);

        // glitch filter
        do_reset();
        sp0 = n_sp;
        pulse(3, 1'b0, 10);
        pulse(8, 1'b0, 20);
        chk("glitch_steps", n_sp - sp0, 1);
        chk("glitch_pos", int'(position), -1);

        // wrap and clear
        do_reset();
        for (int i = 0; i < 127; i++) pulse(4, 1'b1, 1);
        repeat (8) tick();
        chk("pre_wrap", int'(position), 127);
        pulse(4, 1'b1, 10);
        chk("wrap", int'(position), -128);
        pulse(6, 1'b0, 10, 1'b1);
        chk("clr_step", int'(position), -1);

        // stall, restart, and the exact-timeout boundary
        do_reset();
        for (int i = 0; i < 4; i++) pulse(100, 1'b1, 100);
        repeat (1100) tick();
        chk("stall_lvl", int'(stalled), 1);
        pv0 = n_pv;
        pulse(100, 1'b1, 100);
        chk("restart_pv", n_pv - pv0, 0);
        pulse(100, 1'b1, 100);
        chk("second_pv", n_pv - pv0, 1);
        chk("second_per", int'(period), 200);
        pulse(4, 1'b1, TIMEOUT - 4);
        pulse(4, 1'b1, TIMEOUT - 4);
        chk("tmo_edge_per", int'(period), TIMEOUT);
        chk("tmo_edge_stall", int'(stalled), 0);
        pulse(4, 1'b1, TIMEOUT - 3);
        pulse(4, 1'b1, 20);
        chk("tmo_over_stall", int'(stalled), 0);
        chk("tmo_over_per", int'(period), TIMEOUT);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int len;
            int gap;
            len = $urandom_range(1, 10);
            gap = ($urandom_range(0, 29) == 0) ?
                  $urandom_range(950, 1050) : $urandom_range(1, 40);
            pulse(len, 1'($urandom_range(0, 1)), gap, 1'b0, 1'b1);
        end

        // async reset in the middle of a run
        pulse(50, 1'b1, 50);
        step_in = 1'b1;
        dir_in  = 1'b1;
        exp_q.push_back('{cyc + SYNC + MIN_HIGH, 1'b1});
        repeat (20) tick();
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        chk_reset_outputs("async");
        exp_q.delete();
        step_in = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        reset_model();
        mon_en = 1'b1;
        pv0 = n_pv;
        pulse(5, 1'b0, 20);
        chk("post_rst_pos", int'(position), -1);
        chk("post_rst_pv", n_pv - pv0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
